// File: rtl/ss_read_data.sv
// Sequential RAM reader: walks si..ei (inclusive, wrapping) and forwards each word with a valid strobe; optional SS_READ_DATA_REG_OUT_EN adds an output register stage.
// Latency: issue -> valid 1 cycle (2 with SS_READ_DATA_REG_OUT_EN); done pulses with the last word. i_en_read_data=0 stalls the walk without loss.
module ss_read_data #(
    parameter int SIZE_ADDR = 6,
    parameter int SIZE_DATA = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start_read_data,
    input  logic                 i_en_read_data,
    input  logic [SIZE_ADDR-1:0] i_si_ram,
    input  logic [SIZE_ADDR-1:0] i_ei_ram,
    input  logic [SIZE_DATA-1:0] i_data_ram,
    output logic [SIZE_ADDR-1:0] o_addr_ram,
    output logic [SIZE_DATA-1:0] o_data_ram,
    output logic                 o_data_valid,
    output logic                 o_done_read_data
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT_LAST} state_t;

`ifdef SS_READ_DATA_REG_OUT_EN
    localparam logic WAIT_EXTRA = 1'b1;
`else
    localparam logic WAIT_EXTRA = 1'b0;
`endif

    state_t               r_state, w_state_nxt;
    logic [SIZE_ADDR-1:0] r_addr, w_addr_nxt;
    logic [SIZE_ADDR-1:0] r_end, w_end_nxt;
    logic                 r_issue, w_issue_nxt;
    logic                 r_last, w_last_nxt;
    logic                 r_wait, w_wait_nxt;
    logic [SIZE_DATA-1:0] w_data_gated;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_end   <= '0;
            r_issue <= 1'b0;
            r_last  <= 1'b0;
            r_wait  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_end   <= w_end_nxt;
            r_issue <= w_issue_nxt;
            r_last  <= w_last_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_end_nxt   = r_end;
        w_issue_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_wait_nxt  = 1'b0;
        if (i_start_read_data) begin
            // A restart in READ still lets the word on the RAM port land, but never as a "last" word.
            w_state_nxt = S_READ;
            w_addr_nxt  = i_si_ram;
            w_end_nxt   = i_ei_ram;
            w_issue_nxt = (r_state == S_READ) && i_en_read_data;
        end else begin
            case (r_state)
                S_READ: begin
                    if (i_en_read_data) begin
                        w_issue_nxt = 1'b1;
                        w_last_nxt  = (r_addr == r_end);
                        if (r_addr == r_end) w_state_nxt = S_WAIT_LAST;
                        else                 w_addr_nxt  = r_addr + 1'b1;
                    end
                end
                S_WAIT_LAST: begin
                    if (r_wait == WAIT_EXTRA) w_state_nxt = S_IDLE;
                    else                      w_wait_nxt  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_addr_ram   = r_addr;
    assign w_data_gated = r_issue ? i_data_ram : '0;

`ifdef SS_READ_DATA_REG_OUT_EN
    logic [SIZE_DATA-1:0] r_data_out;
    logic                 r_valid_out;
    logic                 r_done_out;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_done_out  <= 1'b0;
        end else begin
            r_data_out  <= w_data_gated;
            r_valid_out <= r_issue;
            r_done_out  <= r_issue & r_last;
        end
    end

    assign o_data_ram       = r_data_out;
    assign o_data_valid     = r_valid_out;
    assign o_done_read_data = r_done_out;
`else
    assign o_data_ram       = w_data_gated;
    assign o_data_valid     = r_issue;
    assign o_done_read_data = r_issue & r_last;
`endif

endmodule

// File: tb/tb_ss_read_data.sv
// Bench for ss_read_data: RAM model mem[a]=a+0x10, expected word stream built from si/ei arithmetic.
module tb_ss_read_data;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          en;
    logic [AW-1:0] si;
    logic [AW-1:0] ei;
    logic [DW-1:0] ram_q;
    logic [AW-1:0] o_addr_ram;
    logic [DW-1:0] o_data_ram;
    logic          o_data_valid;
    logic          o_done_read_data;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q[$];
    bit            last_q[$];
    int            checks = 0;
    int            failures = 0;
    int            done_cnt = 0;
    int            wcnt = 0;

    always #5 clk = ~clk;

    ss_read_data #(.SIZE_ADDR(AW), .SIZE_DATA(DW)) dut (
        .i_clk(clk), .i_rst(rst), .i_start_read_data(start), .i_en_read_data(en),
        .i_si_ram(si), .i_ei_ram(ei), .i_data_ram(ram_q),
        .o_addr_ram(o_addr_ram), .o_data_ram(o_data_ram),
        .o_data_valid(o_data_valid), .o_done_read_data(o_done_read_data)
    );

    always @(posedge clk) ram_q <= mem[o_addr_ram];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (o_done_read_data) chk("done_has_valid", o_data_valid, 1);
        if (o_data_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", o_data_valid, 0);
            end else begin
                logic [DW-1:0] e;
                bit            l;
                e = exp_q.pop_front();
                l = last_q.pop_front();
                chk("data", o_data_ram, e);
                chk("done", o_done_read_data, l);
                wcnt++;
            end
            if (o_done_read_data) done_cnt++;
        end
    end

    task automatic load_expect(input int s, input int e);
        int n;
        n = ((e - s + DEPTH) % DEPTH) + 1;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(DW'(((s + k) % DEPTH) + 16));
            last_q.push_back(k == n - 1);
        end
    endtask

    // mode 0: en always 1; mode 1: 1,1,0,0,0 then 1; mode 2: random en
    task automatic run_txn(input int s, input int e, input int mode);
        int d0;
        int cyc;
        load_expect(s, e);
        d0 = done_cnt;
        start = 1'b1; en = 1'b1;
        si = AW'(s); ei = AW'(e);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (done_cnt == d0 && cyc < 1000) begin
            case (mode)
                1:       en = !(cyc >= 2 && cyc <= 4);
                2:       en = 1'($urandom_range(0, 1));
                default: en = 1'b1;
            endcase
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_count", done_cnt - d0, 1);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("leftover", exp_q.size(), 0);
    endtask

    initial begin
        int w0;
        int d0;
        int cyc;
        for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a + 16);
        rst = 1'b1; start = 1'b0; en = 1'b0; si = '0; ei = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", o_addr_ram, 0);
        chk("rst_valid", o_data_valid, 0);
        chk("rst_done", o_done_read_data, 0);
        chk("rst_data", o_data_ram, 0);
        rst = 1'b0;
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_en_no_valid", o_data_valid, 0);

        run_txn(5, 10, 0);
        run_txn(0, 3, 0);
        run_txn(8, 12, 1);
        run_txn(7, 7, 0);
        run_txn(62, 1, 0);

        // reset part-way through a transaction
        load_expect(5, 10);
        w0 = wcnt; d0 = done_cnt;
        start = 1'b1; en = 1'b1; si = AW'(5); ei = AW'(10);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (wcnt - w0 < 2 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("pre_reset_words", (wcnt - w0 >= 2), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        last_q.delete();
        chk("mid_rst_valid", o_data_valid, 0);
        chk("mid_rst_done", o_done_read_data, 0);
        chk("mid_rst_addr", o_addr_ram, 0);
        chk("mid_rst_data", o_data_ram, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("no_done_after_rst", done_cnt - d0, 0);
        run_txn(5, 10, 0);

        for (int t = 0; t < 20; t++) begin
            run_txn($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                    (t % 2 == 0) ? 2 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
